instr_fetch_buffer: RTL and testbench

Decoupled instruction fetch stage that sits directly upstream of the decode/register-file stage. It owns the word-addressed fetch PC and issues one-at-a-time read requests to a variable-latency instruction memory. Returned words are buffered with their PCs in a small FIFO and presented to decode through a valid/ready handshake. Branch, jump and JR targets arrive on a redirect port that flushes the buffer and any stale in-flight fetch.

---
 rtl/instr_fetch_buffer.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Decoupled instruction fetch stage. It owns the fetch PC and keeps at most one
// request outstanding to a variable-latency memory. Returned words are queued
// with their PCs for decode, and a redirect flushes the queue and any stale
// in-flight response.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // FETCH: nothing outstanding; WAIT: response wanted; DRAIN: response to be dropped
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   w_req_pc_nxt;

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_buf_data [DEPTH];
    logic [31:0]   r_buf_pc   [DEPTH];

    logic          w_mem_req;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_valid;

    // A slot is reserved at issue time, so the check uses the current count only
    assign w_mem_req = (r_state == S_FETCH) && (r_count < CW'(DEPTH)) && !redirect_valid;
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && instr_ready && !redirect_valid;

    // Next-state, fetch address and push decisions; redirect overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_push         = 1'b0;
        w_flush        = 1'b0;

        if (redirect_valid) begin
            w_flush        = 1'b1;
            w_fetch_pc_nxt = redirect_pc;
            if ((r_state != S_FETCH) && !mem_rvalid) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_mem_req) begin
                        w_req_pc_nxt = r_fetch_pc;
                        w_state_nxt  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_req_pc + 32'd1;
                        w_state_nxt    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (mem_rvalid) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch and request address registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 32'd0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
        end
    end

    // Queue pointers and occupancy; flush clears regardless of push/pop
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are only observable through a valid head
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= mem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    // Output drive; head fields read zero whenever the queue is empty
    always_comb begin
        mem_req     = w_mem_req;
        mem_addr    = r_fetch_pc;
        instr_valid = w_valid;
        instr_out   = 32'd0;
        instr_pc    = 32'd0;
        if (w_valid) begin
            instr_out = r_buf_data[r_rd_ptr];
            instr_pc  = r_buf_pc[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: a transaction-level model (queue of pc/word
// pairs plus an outstanding-request flag) and a latency-programmable memory.
module tb_instr_fetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK;
    logic        RST;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // reference model
    entry_t      m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_disc;
    bit          m_known;
    bit          m_after_rst;

    // memory model
    bit          p_busy;
    bit          p_stale;
    int          p_cnt;
    logic [31:0] p_addr;
    int          mem_lat;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // One clock cycle: drive inputs, check outputs, advance model and memory
    task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        bit          from_busy;
        bit          rv;
        bit          exp_req;
        bit          exp_pop;
        entry_t      e;
        @(negedge CLK);
        from_busy      = p_busy && (p_cnt == 0);
        rv             = from_busy || p_stale;
        RST            = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        mem_rvalid     = rv;
        mem_rdata      = from_busy ? mem_word(p_addr) : (rv ? 32'hDEAD_BEEF : 32'h0);
        #1;
        exp_req = !m_out && (m_q.size() < DEPTH) && !redir;
        if (m_known) begin
            check_eq("mem_req", 32'(mem_req), 32'(exp_req));
            check_eq("mem_addr", mem_addr, m_fetch_pc);
            check_eq("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check_eq("instr_pc", instr_pc, m_q[0].pc);
                check_eq("instr_out", instr_out, m_q[0].data);
            end else if (m_after_rst) begin
                check_eq("rst_instr_pc", instr_pc, 32'h0);
                check_eq("rst_instr_out", instr_out, 32'h0);
            end
        end

        exp_pop     = (m_q.size() != 0) && rdy && !redir;
        m_after_rst = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_fetch_pc  = RESET_PC;
            m_out       = 1'b0;
            m_disc      = 1'b0;
            m_known     = 1'b1;
            m_after_rst = 1'b1;
        end else if (redir) begin
            m_q.delete();
            m_fetch_pc = rpc;
            m_disc     = m_out && !rv;
            m_out      = m_disc;
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (m_out && rv) begin
                if (!m_disc) begin
                    e.pc   = m_req_pc;
                    e.data = mem_rdata;
                    m_q.push_back(e);
                    m_fetch_pc = m_req_pc + 32'd1;
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (exp_req) begin
                m_req_pc = m_fetch_pc;
                m_out    = 1'b1;
            end
        end

        if (!rst) begin
            p_stale = p_busy && !from_busy;
            p_busy  = 1'b0;
        end else begin
            p_stale = 1'b0;
            if (from_busy) p_busy = 1'b0;
            else if (p_busy) p_cnt--;
            if (mem_req) begin
                p_busy = 1'b1;
                p_cnt  = mem_lat - 1;
                p_addr = mem_addr;
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        n_checks = 0; n_errors = 0;
        m_known = 0; m_after_rst = 0; m_out = 0; m_disc = 0;
        m_fetch_pc = RESET_PC; m_req_pc = 0;
        p_busy = 0; p_stale = 0; p_cnt = 0; p_addr = 0; mem_lat = 1;
        RST = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
        mem_rvalid = 0; mem_rdata = 0;

        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // stream at 1-cycle latency
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // back-pressure until full, then release
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("full_no_req", 32'(mem_req), 32'h0);
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // redirect while idle with entries queued
        for (int i = 0; i < 12 && !(m_q.size() >= 2 && !m_out); i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("t3_setup", 32'(m_q.size() >= 2 && !m_out), 32'h1);
        cycle(1'b1, 1'b1, 32'h40, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // redirect one cycle after a request at latency 3
        mem_lat = 3;
        for (int i = 0; i < 12 && !m_out; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("t4_setup", 32'(m_out), 32'h1);
        cycle(1'b1, 1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // redirect coincident with response and pop
        mem_lat = 1;
        for (int i = 0; i < 16 && !(m_out && m_q.size() >= 1); i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("t5_setup", 32'(m_out && m_q.size() >= 1), 32'h1);
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // reset while waiting with three entries queued; late response follows
        mem_lat = 3;
        for (int i = 0; i < 30 && !(m_out && m_q.size() == 3); i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("t6_setup", 32'(m_out && m_q.size() == 3), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            mem_lat = $urandom_range(1, 4);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 15) == 0),
                  rpc,
                  ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
